// File: rtl/d_lock_pkg.sv
// d_lock_pkg: shared state codes, lock policy defaults and lockout duration helper
package d_lock_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, GRANT = 3'd1, WARN = 3'd2, LOCKOUT = 3'd3} state_t;
    localparam int unsigned WARN_LIMIT  = 2;
    localparam int unsigned MAX_ERR     = 7;
    localparam int unsigned BASE_LOCK_S = 60;
    localparam int unsigned WARN_TICKS  = 2;
    // (n-3) wraps in 3 bits; callers only use it for n>=3
    function automatic int unsigned lock_dur(logic [2:0] n, int unsigned base);
        logic [2:0] d;
        d = n - 3'd3;
        return (32'(d) * 32'(d) + 32'd1) * base;
    endfunction
endpackage

// File: rtl/d_module_attempt_ctrl_if.sv
// d_module_attempt_ctrl_if: comparator-to-controller attempt handshake
interface d_module_attempt_ctrl_if;
    logic attempt_valid;
    logic attempt_match;
    logic attempt_ready;
    modport master (output attempt_valid, attempt_match, input attempt_ready);
    modport slave (input attempt_valid, attempt_match, output attempt_ready);
endinterface

// File: rtl/d_tick_downcounter.sv
// d_tick_downcounter: 10-bit loadable down-counter stepped by a tick enable
module d_tick_downcounter (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       load,
    input  logic [9:0] load_val,
    input  logic       tick,
    output logic [9:0] count,
    output logic       is_zero,
    output logic       is_one
);
    assign is_zero = count == 10'd0;
    assign is_one  = count == 10'd1;
    always_ff @(posedge clk_in) begin
        if (reset) count <= 10'd0;
        else if (load) count <= load_val;
        else if (tick && !is_zero) count <= count - 10'd1;
    end
endmodule

// File: rtl/d_module_attempt_ctrl.sv
// d_module_attempt_ctrl: attempt sequencer with warn/escalating-lockout failure policy
module d_module_attempt_ctrl #(
    parameter int unsigned WARN_LIMIT  = d_lock_pkg::WARN_LIMIT,
    parameter int unsigned MAX_ERR     = d_lock_pkg::MAX_ERR,
    parameter int unsigned BASE_LOCK_S = d_lock_pkg::BASE_LOCK_S,
    parameter int unsigned WARN_TICKS  = d_lock_pkg::WARN_TICKS
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      tick_1hz,
    input  logic                      relock,
    d_module_attempt_ctrl_if.slave    att,
    output logic                      enb_lock,
    output logic                      gen_stop,
    output logic [2:0]                error_counter,
    output logic [9:0]                lock_remaining,
    output logic [2:0]                state_o
);
    import d_lock_pkg::*;
    state_t state, next;
    logic [2:0] n, err_next;
    logic warn_load, lock_load, warn_one, warn_zero, lock_one, lock_zero;
    logic [9:0] warn_cnt;
    int unsigned dur;
    assign n = (error_counter == 3'(MAX_ERR)) ? error_counter : error_counter + 3'd1;
    assign dur = lock_dur(n, BASE_LOCK_S);
    assign state_o = state;
    always_comb begin
        next = state;
        err_next = error_counter;
        warn_load = 1'b0;
        lock_load = 1'b0;
        case (state)
            IDLE: if (att.attempt_valid) begin
                if (att.attempt_match) begin
                    next = GRANT;
                    err_next = 3'd0;
                end else begin
                    err_next = n;
                    warn_load = n <= 3'(WARN_LIMIT);
                    lock_load = !warn_load;
                    next = warn_load ? WARN : LOCKOUT;
                end
            end
            GRANT:   next = relock ? IDLE : GRANT;
            WARN:    next = (tick_1hz && warn_one) ? IDLE : WARN;
            LOCKOUT: next = (tick_1hz && lock_one) ? IDLE : LOCKOUT;
            default: next = IDLE;
        endcase
    end
    // Flag outputs are registered from the next state so they change together with state_o
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
            error_counter <= 3'd0;
            enb_lock <= 1'b0;
            gen_stop <= 1'b0;
            att.attempt_ready <= 1'b1;
        end else begin
            state <= next;
            error_counter <= err_next;
            enb_lock <= next == GRANT;
            gen_stop <= next == LOCKOUT;
            att.attempt_ready <= next == IDLE;
        end
    end
    d_tick_downcounter u_lock (
        .clk_in(clk_in), .reset(reset), .load(lock_load), .load_val(dur[9:0]),
        .tick(tick_1hz && state == LOCKOUT), .count(lock_remaining), .is_zero(lock_zero), .is_one(lock_one)
    );
    d_tick_downcounter u_warn (
        .clk_in(clk_in), .reset(reset), .load(warn_load), .load_val(10'(WARN_TICKS)),
        .tick(tick_1hz && state == WARN), .count(warn_cnt), .is_zero(warn_zero), .is_one(warn_one)
    );
    // Counters must be live exactly while their state is; duration must fit 10 bits
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            assert (!lock_load || dur < 32'd1024);
            assert (state != LOCKOUT || !lock_zero);
            assert (state != WARN || !warn_zero);
            assert (state == WARN || warn_cnt == 10'd0);
        end
    end
endmodule
